ift_fetch_scheduler: RTL and testbench
======================================

# ift_fetch_scheduler

Per-SM instruction-fetch scheduler sitting in front of the L1I tag lookup stage. Owns every warp's fetch PC, tracks per-warp fetch state (ready / waiting on an L1I fill) and instruction-buffer credits, and picks one eligible warp per cycle round-robin to present to the tag stage. Absorbs L1I miss, line-fill-complete and branch-redirect events from later stages.

## Interface
- NUM_WARPS, 4, warps per SM (power of two)
- PC_WIDTH, 32, fetch address width
- RESET_PC, 32'h0, PC loaded into every warp at reset
- IBUF_CREDITS, 2, instruction-buffer entries per warp
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- warp_enable  in  NUM_WARPS  warp active mask from dispatch
- fetch_valid  out  1  a warp is offered to the tag stage
- fetch_ready  in  1  tag stage accepts (not stalled)
- fetch_warp_idx  out  $clog2(NUM_WARPS)  offered warp
- fetch_pc  out  PC_WIDTH  offered PC
- miss_valid  in  1  tag stage reports L1I miss
- miss_warp_idx  in  $clog2(NUM_WARPS)  warp that missed
- miss_pc  in  PC_WIDTH  PC that missed
- fill_done  in  1  L1I line fill for a warp completed
- fill_warp_idx  in  $clog2(NUM_WARPS)  warp whose fill completed
- redirect_valid  in  1  branch redirect
- redirect_warp_idx  in  $clog2(NUM_WARPS)  redirected warp
- redirect_pc  in  PC_WIDTH  new PC
- ibuf_pop  in  NUM_WARPS  decode consumed one entry of warp w
- warp_waiting  out  NUM_WARPS  warp in WAIT_FILL (perf/debug)

## Operation
- Per warp: pc register, state {READY, WAIT_FILL}, credit counter width $clog2(IBUF_CREDITS+1).
- Reset: pc=RESET_PC, state=READY, credit=IBUF_CREDITS, RR pointer=0; fetch_valid=0 and warp_waiting=0 during reset.
- eligible[w] = warp_enable[w] & state==READY & credit>0 & !(miss_valid & miss_warp_idx==w) & !(redirect_valid & redirect_warp_idx==w).
- fetch_valid = |eligible; RR arbiter picks first eligible at or after pointer; fetch_pc = pc of that warp. Outputs combinational from registered state + same-cycle event inputs; tag stage samples only on handshake.
- Handshake (fetch_valid & fetch_ready): pc[w] += 4 (mod 2^PC_WIDTH, wraps), credit[w] -= 1, pointer = w+1 mod NUM_WARPS. No handshake: pointer holds.
- Miss for w: pc[w]=miss_pc, state=WAIT_FILL, credit[w] += 1.
- fill_done for w: state=READY (ignored if already READY).
- Redirect for w: pc[w]=redirect_pc, credit[w]=IBUF_CREDITS (decode flushes w's buffer); state unchanged — a WAIT_FILL warp stays waiting until fill_done.
- ibuf_pop[w]: credit[w] += 1. Credit updates same cycle sum (fetch -1, pop +1, miss +1). Result > IBUF_CREDITS is a protocol error: assertion, counter saturates.
- Same-warp priority in one cycle: redirect > miss > fill_done > fetch/pop. Miss ignored (pc/state) when redirect hits same warp; its credit return is superseded by the credit reload.
- warp_enable low: warp ineligible, state/pc/credits held; events still applied.

## Timing
- Fetch-to-refetch: warp granted in cycle N may be granted again in N+1 at pc+4 (if sole eligible with credit).
- miss/fill_done/redirect in cycle N: masks w in N (miss/redirect), new state/pc visible N+1.
- ibuf_pop in N restores eligibility in N+1.
- No combinational path from fetch_ready to fetch_valid/fetch_warp_idx/fetch_pc.

## Structure
- Package defines: warp_idx_t, fetch_pc_t (reuse l1i_addr_t), warp_fetch_state_t enum {READY, WAIT_FILL}, IBUF_CREDITS constant.
- One sub-module: ift_rr_arbiter (request vector, update_en, one-hot grant; pointer advances only on update_en). Grant index via existing oh2idx.

## Test plan
- Reset, warp_enable=4'b1111, fetch_ready=1, no pops -> grants w0,w1,w2,w3,w0,w1,w2,w3 with PCs 0,0,0,0,4,4,4,4; then fetch_valid=0 (credits exhausted).
- w2 credit 0, ibuf_pop[2] in cycle N -> w2 granted from N+1 at next PC.
- miss w1 pc=0x100 -> w1 not offered; warp_waiting[1]=1; fill_done w1 at cycle N -> w1 offered at 0x100 in N+1.
- fetch_ready=0 for 3 cycles with 4'b1011 enabled -> pointer and PCs unchanged; first accepted grant is the one offered before stall.
- Same cycle redirect w0 pc=0x2000 and miss w0 pc=0x40 -> pc[0]=0x2000, state READY, credit=IBUF_CREDITS.
- pc=32'hFFFF_FFFC fetched -> pc wraps to 0; synchronous reset mid-WAIT_FILL -> all warps READY, pc=RESET_PC next cycle.

Source files
------------

// File: rtl/ift_fetch_scheduler_pkg.sv
// Shared types, sizing constants and helpers for the instruction-fetch scheduler.
package ift_fetch_scheduler_pkg;

    localparam int NUM_WARPS    = 4;
    localparam int PC_WIDTH     = 32;
    localparam int IBUF_CREDITS = 2;

    localparam int WARP_IDX_W = $clog2(NUM_WARPS);
    localparam int CREDIT_W   = $clog2(IBUF_CREDITS + 1);

    typedef logic [WARP_IDX_W-1:0] warp_idx_t;
    typedef logic [PC_WIDTH-1:0]   l1i_addr_t;
    typedef l1i_addr_t             fetch_pc_t;
    typedef logic [NUM_WARPS-1:0]  warp_mask_t;
    typedef logic [CREDIT_W-1:0]   credit_t;
    // One extra bit so fetch/pop/miss can be summed before saturation.
    typedef logic [CREDIT_W:0]     credit_sum_t;

    typedef enum logic {
        READY     = 1'b0,
        WAIT_FILL = 1'b1
    } warp_fetch_state_t;

    localparam fetch_pc_t DEFAULT_RESET_PC = '0;
    localparam credit_t   CREDIT_MAX       = credit_t'(IBUF_CREDITS);
    localparam fetch_pc_t PC_STEP          = fetch_pc_t'(4);

    // One-hot to binary index; an all-zero input yields index 0.
    function automatic warp_idx_t oh2idx(input warp_mask_t oh);
        warp_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (oh[i]) idx = idx | warp_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ift_fetch_scheduler_if.sv
// Fetch-side bus between the scheduler (master) and the tag/decode pipeline (slave).
interface ift_fetch_scheduler_if import ift_fetch_scheduler_pkg::*; ();

    warp_mask_t warp_enable;
    logic       fetch_valid;
    logic       fetch_ready;
    warp_idx_t  fetch_warp_idx;
    fetch_pc_t  fetch_pc;
    logic       miss_valid;
    warp_idx_t  miss_warp_idx;
    fetch_pc_t  miss_pc;
    logic       fill_done;
    warp_idx_t  fill_warp_idx;
    logic       redirect_valid;
    warp_idx_t  redirect_warp_idx;
    fetch_pc_t  redirect_pc;
    warp_mask_t ibuf_pop;
    warp_mask_t warp_waiting;

    modport master (
        input  warp_enable, fetch_ready,
        input  miss_valid, miss_warp_idx, miss_pc,
        input  fill_done, fill_warp_idx,
        input  redirect_valid, redirect_warp_idx, redirect_pc,
        input  ibuf_pop,
        output fetch_valid, fetch_warp_idx, fetch_pc, warp_waiting
    );

    modport slave (
        output warp_enable, fetch_ready,
        output miss_valid, miss_warp_idx, miss_pc,
        output fill_done, fill_warp_idx,
        output redirect_valid, redirect_warp_idx, redirect_pc,
        output ibuf_pop,
        input  fetch_valid, fetch_warp_idx, fetch_pc, warp_waiting
    );

endinterface

// File: rtl/ift_fetch_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves past the winner only when the grant is consumed.
module ift_rr_arbiter
    import ift_fetch_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  warp_mask_t req_i,
    input  logic       update_en_i,
    output warp_mask_t grant_o
);

    warp_idx_t ptr_q;
    warp_idx_t ptr_d;
    warp_idx_t scan_idx;
    logic      found;

    // Pointer register.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    // Scan requesters starting at the pointer; index arithmetic wraps since NUM_WARPS is a power of two.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant_o  = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            scan_idx = ptr_q + warp_idx_t'(k);
            if (!found && req_i[scan_idx]) begin
                grant_o[scan_idx] = 1'b1;
                found             = 1'b1;
            end
        end
    end

    // Advance past the winner on a consumed grant, otherwise hold.
    always_comb begin
        ptr_d = ptr_q;
        if (update_en_i && found) ptr_d = oh2idx(grant_o) + warp_idx_t'(1);
    end

endmodule

// File: rtl/ift_fetch_scheduler.sv
// Per-SM instruction-fetch scheduler: owns per-warp PC, fill state and
// ibuf credits, and offers one eligible warp per cycle to the L1I tag stage.
module ift_fetch_scheduler
    import ift_fetch_scheduler_pkg::*;
#(
    parameter fetch_pc_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                reset,
    ift_fetch_scheduler_if.master bus
);

    fetch_pc_t         pc_q     [NUM_WARPS];
    fetch_pc_t         pc_d     [NUM_WARPS];
    warp_fetch_state_t state_q  [NUM_WARPS];
    warp_fetch_state_t state_d  [NUM_WARPS];
    credit_t           credit_q [NUM_WARPS];
    credit_t           credit_d [NUM_WARPS];
    credit_sum_t       credit_sum [NUM_WARPS];

    warp_mask_t redirect_hit;
    warp_mask_t miss_hit;
    warp_mask_t fill_hit;
    warp_mask_t fetch_hit;
    warp_mask_t eligible;
    warp_mask_t grant;
    warp_mask_t credit_ovf;
    warp_idx_t  grant_idx;
    logic       handshake;

    ift_rr_arbiter u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       (eligible),
        .update_en_i (handshake),
        .grant_o     (grant)
    );

    // fetch_valid depends only on state and event inputs, never on fetch_ready.
    assign handshake = bus.fetch_valid && bus.fetch_ready;
    assign grant_idx = oh2idx(grant);

    // Decode the single-warp event buses into per-warp hit vectors.
    always_comb begin
        redirect_hit = '0;
        miss_hit     = '0;
        fill_hit     = '0;
        fetch_hit    = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            redirect_hit[w] = bus.redirect_valid && (bus.redirect_warp_idx == warp_idx_t'(w));
            miss_hit[w]     = bus.miss_valid     && (bus.miss_warp_idx     == warp_idx_t'(w));
            fill_hit[w]     = bus.fill_done      && (bus.fill_warp_idx     == warp_idx_t'(w));
            fetch_hit[w]    = handshake && grant[w];
        end
    end

    // Per-warp state, PC and credit registers.
    always_ff @(posedge clk) begin
        // NOTE: these per-warp arrays are architectural state, not storage, so every entry is reset.
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w]     <= RESET_PC;
                state_q[w]  <= READY;
                credit_q[w] <= CREDIT_MAX;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w]     <= pc_d[w];
                state_q[w]  <= state_d[w];
                credit_q[w] <= credit_d[w];
            end
        end
    end

    // Next state with same-warp priority redirect > miss > fill > fetch/pop.
    always_comb begin
        credit_ovf = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            pc_d[w]       = pc_q[w];
            state_d[w]    = state_q[w];
            credit_sum[w] = {1'b0, credit_q[w]}
                          + credit_sum_t'(bus.ibuf_pop[w])
                          + credit_sum_t'(miss_hit[w])
                          - credit_sum_t'(fetch_hit[w]);
            credit_d[w]   = credit_q[w];

            if (redirect_hit[w]) begin
                pc_d[w] = bus.redirect_pc;
            end else if (miss_hit[w]) begin
                pc_d[w] = bus.miss_pc;
            end else if (fetch_hit[w]) begin
                pc_d[w] = pc_q[w] + PC_STEP;
            end

            // A redirect leaves the fill state alone; only the miss is dropped.
            if (miss_hit[w] && !redirect_hit[w]) begin
                state_d[w] = WAIT_FILL;
            end else if (fill_hit[w]) begin
                state_d[w] = READY;
            end

            // Redirect flushes the warp's ibuf, so credits reload to full.
            if (redirect_hit[w]) begin
                credit_d[w] = CREDIT_MAX;
            end else if (credit_sum[w] > credit_sum_t'(CREDIT_MAX)) begin
                credit_d[w]   = CREDIT_MAX;
                credit_ovf[w] = 1'b1;
            end else begin
                credit_d[w] = credit_sum[w][CREDIT_W-1:0];
            end
        end
    end

    // Eligibility, offered warp and debug outputs; all forced idle during reset.
    always_comb begin
        eligible          = '0;
        bus.warp_waiting  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            eligible[w] = !reset
                        && bus.warp_enable[w]
                        && (state_q[w] == READY)
                        && (credit_q[w] != '0)
                        && !miss_hit[w]
                        && !redirect_hit[w];
            bus.warp_waiting[w] = !reset && (state_q[w] == WAIT_FILL);
        end
        bus.fetch_valid    = |eligible;
        bus.fetch_warp_idx = grant_idx;
        bus.fetch_pc       = pc_q[grant_idx];
    end

    // More ibuf returns than entries means the decode side broke the credit protocol.
    assert property (@(posedge clk) disable iff (reset) credit_ovf == '0);

endmodule

// File: tb/tb_ift_fetch_scheduler.sv
// Self-checking bench: directed vector table plus a model-driven random phase,
// both feeding expectations through a scoreboard queue.
module tb_ift_fetch_scheduler;
    import ift_fetch_scheduler_pkg::*;

    typedef struct {
        logic       rst;
        logic [3:0] en;
        logic       rdy;
        logic [3:0] pop;
        logic       mv;
        logic [1:0] mw;
        logic [31:0] mpc;
        logic       fd;
        logic [1:0] fw;
        logic       rv;
        logic [1:0] rw;
        logic [31:0] rpc;
        logic       ev;
        logic [1:0] ew;
        logic [31:0] epc;
        logic [3:0] ewait;
    } vec_t;

    typedef struct {
        logic        ev;
        logic [1:0]  ew;
        logic [31:0] epc;
        logic [3:0]  ewait;
        string       name;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   vec_no;

    vec_t vecs[$];
    exp_t sb[$];

    ift_fetch_scheduler_if bus ();

    ift_fetch_scheduler #(.RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(input logic rst, input logic [3:0] en, input logic rdy,
                               input logic [3:0] pop, input logic ev, input logic [1:0] ew,
                               input logic [31:0] epc, input logic [3:0] ewait);
        vec_t t;
        t.rst = rst; t.en = en; t.rdy = rdy; t.pop = pop;
        t.mv = 1'b0; t.mw = '0; t.mpc = '0;
        t.fd = 1'b0; t.fw = '0;
        t.rv = 1'b0; t.rw = '0; t.rpc = '0;
        t.ev = ev; t.ew = ew; t.epc = epc; t.ewait = ewait;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, push its expectation, compare at negedge.
    task automatic apply(input vec_t t, input string name);
        exp_t e;
        exp_t got;
        reset                 = t.rst;
        bus.warp_enable       = t.en;
        bus.fetch_ready       = t.rdy;
        bus.ibuf_pop          = t.pop;
        bus.miss_valid        = t.mv;
        bus.miss_warp_idx     = t.mw;
        bus.miss_pc           = t.mpc;
        bus.fill_done         = t.fd;
        bus.fill_warp_idx     = t.fw;
        bus.redirect_valid    = t.rv;
        bus.redirect_warp_idx = t.rw;
        bus.redirect_pc       = t.rpc;
        e.ev = t.ev; e.ew = t.ew; e.epc = t.epc; e.ewait = t.ewait; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        check({got.name, ".valid"}, 32'(bus.fetch_valid), 32'(got.ev));
        check({got.name, ".waiting"}, 32'(bus.warp_waiting), 32'(got.ewait));
        if (got.ev) begin
            check({got.name, ".idx"}, 32'(bus.fetch_warp_idx), 32'(got.ew));
            check({got.name, ".pc"}, bus.fetch_pc, got.epc);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        vec_t t;
        int   mcred [4];
        logic [31:0] mpc [4];
        logic [1:0]  mptr;
        logic [3:0]  pop;
        logic        rdy;
        logic        ev;
        logic [1:0]  ew;

        checks   = 0;
        failures = 0;

        // Reset, then round-robin over all warps until credits run out.
        vecs.push_back(v(1, 4'hF, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 4'hF, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) vecs.push_back(v(0, 4'hF, 1, 0, 1, 2'(i % 4), (i < 4) ? 32'h0 : 32'h4, 0));
        vecs.push_back(v(0, 4'hF, 1, 0, 0, 0, 0, 0));
        // Pop on w2 restores eligibility the next cycle only.
        vecs.push_back(v(0, 4'hF, 1, 4'b0100, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'hF, 1, 0, 1, 2, 32'h8, 0));
        vecs.push_back(v(0, 4'hF, 1, 0, 0, 0, 0, 0));
        // Miss on w1 masks it, waits, fill_done releases it at the miss PC.
        vecs.push_back(v(1, 4'hF, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'b0010, 1, 0, 1, 1, 32'h0, 0));
        t = v(0, 4'b0010, 1, 0, 0, 0, 0, 0); t.mv = 1; t.mw = 1; t.mpc = 32'h100;
        vecs.push_back(t);
        vecs.push_back(v(0, 4'b0010, 1, 0, 0, 0, 0, 4'b0010));
        t = v(0, 4'b0010, 1, 0, 0, 0, 0, 4'b0010); t.fd = 1; t.fw = 1;
        vecs.push_back(t);
        vecs.push_back(v(0, 4'b0010, 1, 0, 1, 1, 32'h100, 0));
        // Stall with 1011 enabled: the offer holds, then grants resume in order.
        vecs.push_back(v(1, 4'hF, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(v(0, 4'b1011, 0, 0, 1, 0, 32'h0, 0));
        vecs.push_back(v(0, 4'b1011, 1, 0, 1, 0, 32'h0, 0));
        vecs.push_back(v(0, 4'b1011, 1, 0, 1, 1, 32'h0, 0));
        vecs.push_back(v(0, 4'b1011, 1, 0, 1, 3, 32'h0, 0));
        vecs.push_back(v(0, 4'b1011, 1, 0, 1, 0, 32'h4, 0));
        // Redirect and miss on w0 together, with w0 out of credit.
        vecs.push_back(v(1, 4'hF, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'b0001, 1, 0, 1, 0, 32'h0, 0));
        vecs.push_back(v(0, 4'b0001, 1, 0, 1, 0, 32'h4, 0));
        t = v(0, 4'b0001, 1, 0, 0, 0, 0, 0);
        t.rv = 1; t.rw = 0; t.rpc = 32'h2000; t.mv = 1; t.mw = 0; t.mpc = 32'h40;
        vecs.push_back(t);
        vecs.push_back(v(0, 4'b0001, 1, 0, 1, 0, 32'h2000, 0));
        vecs.push_back(v(0, 4'b0001, 1, 0, 1, 0, 32'h2004, 0));
        vecs.push_back(v(0, 4'b0001, 1, 0, 0, 0, 0, 0));
        // PC wrap at the top of the address space.
        vecs.push_back(v(1, 4'hF, 0, 0, 0, 0, 0, 0));
        t = v(0, 4'b1000, 0, 0, 0, 0, 0, 0); t.rv = 1; t.rw = 3; t.rpc = 32'hFFFF_FFFC;
        vecs.push_back(t);
        vecs.push_back(v(0, 4'b1000, 1, 0, 1, 3, 32'hFFFF_FFFC, 0));
        vecs.push_back(v(0, 4'b1000, 1, 0, 1, 3, 32'h0, 0));
        // Reset while w3 sits in WAIT_FILL.
        t = v(0, 4'b1000, 0, 0, 0, 0, 0, 0); t.mv = 1; t.mw = 3; t.mpc = 32'h80;
        vecs.push_back(t);
        vecs.push_back(v(0, 4'b1000, 0, 0, 0, 0, 0, 4'b1000));
        vecs.push_back(v(1, 4'hF, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 4'hF, 1, 0, 1, 0, 32'h0, 0));
        vecs.push_back(v(0, 4'hF, 1, 0, 1, 1, 32'h0, 0));
        vecs.push_back(v(0, 4'b1000, 1, 0, 1, 3, 32'h0, 0));

        reset = 1'b1;
        bus.warp_enable = '0; bus.fetch_ready = 1'b0; bus.ibuf_pop = '0;
        bus.miss_valid = 1'b0; bus.miss_warp_idx = '0; bus.miss_pc = '0;
        bus.fill_done = 1'b0; bus.fill_warp_idx = '0;
        bus.redirect_valid = 1'b0; bus.redirect_warp_idx = '0; bus.redirect_pc = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_no = i;
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Random ready/pop traffic against a reference model, then drain.
        apply(v(1, 4'hF, 0, 0, 0, 0, 0, 0), "rnd_reset");
        for (int w = 0; w < 4; w++) begin
            mcred[w] = IBUF_CREDITS;
            mpc[w]   = 32'h0;
        end
        mptr = 2'd0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            pop = '0;
            rdy = 1'b1;
            if (cyc < 40) begin
                rdy = ($urandom_range(0, 3) != 0);
                for (int w = 0; w < 4; w++) pop[w] = (mcred[w] < IBUF_CREDITS) && ($urandom_range(0, 1) == 1);
            end
            ev = 1'b0;
            ew = '0;
            for (int k = 0; k < 4; k++) begin
                if (!ev && mcred[2'(mptr + 2'(k))] > 0) begin
                    ev = 1'b1;
                    ew = 2'(mptr + 2'(k));
                end
            end
            apply(v(0, 4'hF, rdy, pop, ev, ew, ev ? mpc[ew] : 32'h0, 0), $sformatf("rnd%0d", cyc));
            if (ev && rdy) begin
                mpc[ew]   = mpc[ew] + 32'd4;
                mcred[ew] = mcred[ew] - 1;
                mptr      = ew + 2'd1;
            end
            for (int w = 0; w < 4; w++) if (pop[w]) mcred[w] = mcred[w] + 1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
